sync_updown_counter_n: RTL and testbench

SYNC_UPDOWN_COUNTER_N -- requirements
Module: sync_updown_counter_n

---
 rtl/sync_updown_counter_n.sv | 61 ++++++
 tb/tb_sync_updown_counter_n.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter_n.sv
// Modulo-(MAX_COUNT+1) up/down counter with clear, clamped parallel load,
// a combinational terminal-count flag and a registered wrap pulse.
module sync_updown_counter_n #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             wrap_reg, wrap_next;

  always_comb begin
    tc = en & (up_down ? (q_reg == MAX_Q) : (q_reg == ZERO));
  end

  // The wrap pulse is simply tc captured on a counting edge.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (clear) begin
      q_next = ZERO;
    end else if (load) begin
      q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      wrap_next = tc;
      if (up_down) begin
        q_next = (q_reg == MAX_Q) ? ZERO : q_reg + ONE;
      end else begin
        q_next = (q_reg == ZERO) ? MAX_Q : q_reg - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg    <= ZERO;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  assign Q    = q_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Scoreboard bench: a default 3-bit/7 counter and a 4-bit/9 counter run side by
// side against an arithmetic modulo model; a monitor pops expected Q/wrap per edge.
module tb_sync_updown_counter_n;

  typedef struct {
    int q;
    int w;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       clear_a, load_a, en_a, ud_a;
  logic [2:0] lv_a;
  logic [2:0] q_a;
  logic       tc_a, wrap_a;
  logic       clear_b, load_b, en_b, ud_b;
  logic [3:0] lv_b;
  logic [3:0] q_b;
  logic       tc_b, wrap_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ma_q     = 0;
  int   mb_q     = 0;
  exp_t qa[$];
  exp_t qb[$];

  sync_updown_counter_n dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .load(load_a), .load_val(lv_a),
    .en(en_a), .up_down(ud_a), .Q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  sync_updown_counter_n #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .load(load_b), .load_val(lv_b),
    .en(en_b), .up_down(ud_b), .Q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sequence 0..max treated as a ring of max+1 values.
  function automatic int model_tc(input int q, input int max, input bit en, input bit ud);
    return (en && ((ud && q == max) || (!ud && q == 0))) ? 1 : 0;
  endfunction

  task automatic model_next(input int max, inout int q, input bit c, input bit l,
                            input int lv, input bit en, input bit ud, output int w);
    w = 0;
    if (c) q = 0;
    else if (l) q = (lv < max) ? lv : max;
    else if (en) begin
      w = model_tc(q, max, en, ud);
      q = ud ? (q + 1) % (max + 1) : (q + max) % (max + 1);
    end
  endtask

  task automatic set_a(input bit c, input bit l, input int lv, input bit e, input bit ud);
    clear_a = c; load_a = l; lv_a = 3'(lv); en_a = e; ud_a = ud;
  endtask

  task automatic set_b(input bit c, input bit l, input int lv, input bit e, input bit ud);
    clear_b = c; load_b = l; lv_b = 4'(lv); en_b = e; ud_b = ud;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next one.
  task automatic step();
    int   wa, wb;
    exp_t e;
    #1;
    chk("tc_a", int'(tc_a), model_tc(ma_q, 7, en_a, ud_a));
    chk("tc_b", int'(tc_b), model_tc(mb_q, 9, en_b, ud_b));
    model_next(7, ma_q, clear_a, load_a, int'(lv_a), en_a, ud_a, wa);
    e.q = ma_q; e.w = wa; qa.push_back(e);
    model_next(9, mb_q, clear_b, load_b, int'(lv_b), en_b, ud_b, wb);
    e.q = mb_q; e.w = wb; qb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #1 reset = 1'b0;
    #1;
    chk("rst_q_a", int'(q_a), 0);
    chk("rst_wrap_a", int'(wrap_a), 0);
    chk("rst_q_b", int'(q_b), 0);
    chk("rst_wrap_b", int'(wrap_b), 0);
    ma_q = 0;
    mb_q = 0;
    #1 reset = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("q_a", int'(q_a), e.q);
      chk("wrap_a", int'(wrap_a), e.w);
      $display("edge a: q=%0d wrap=%0d (model q=%0d wrap=%0d)", q_a, wrap_a, e.q, e.w);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("q_b", int'(q_b), e.q);
      chk("wrap_b", int'(wrap_b), e.w);
      $display("edge b: q=%0d wrap=%0d (model q=%0d wrap=%0d)", q_b, wrap_b, e.q, e.w);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    #1;
    chk("reset_q_a", int'(q_a), 0);
    chk("reset_wrap_a", int'(wrap_a), 0);
    chk("reset_tc_idle", int'(tc_a), 0);
    en_a = 1'b1;
    #1 chk("reset_tc_down", int'(tc_a), 1);
    ud_a = 1'b1;
    #1 chk("reset_tc_up", int'(tc_a), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Count up through the 7->0 wrap, then down through 0->7.
    repeat (10) step();
    set_a(1, 0, 0, 0, 0); step();
    set_a(0, 0, 0, 1, 0); repeat (3) step();

    // Clear beats load; clear with en low.
    set_a(0, 1, 5, 0, 0); step();
    set_a(1, 1, 6, 1, 1); step();
    set_a(0, 1, 5, 0, 0); step();
    set_a(1, 0, 0, 0, 0); step();

    // Hold at 3, then alternate direction each edge.
    set_a(0, 1, 3, 0, 0); step();
    set_a(0, 0, 0, 0, 1); repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      set_a(0, 0, 0, 1, (i % 2) == 0);
      step();
    end

    // Mid-cycle reset at Q=4, first edge afterwards counts up.
    set_a(0, 1, 4, 0, 0); step();
    set_a(0, 0, 0, 1, 1);
    async_reset_pulse();
    step();
    set_a(0, 0, 0, 0, 0);

    // Wider counter: clamped load, wrap at 9, load overrides count.
    set_b(0, 1, 12, 0, 0); step();
    set_b(0, 0, 0, 1, 1); step();
    set_b(0, 1, 5, 1, 1); step();
    set_b(0, 1, 15, 0, 0); step();
    set_b(0, 0, 0, 1, 0); repeat (11) step();

    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(1) == 1);
      set_b($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(15),
            $urandom_range(3) != 0, $urandom_range(1) == 1);
      if ($urandom_range(49) == 0) async_reset_pulse();
      step();
    end

    @(posedge clk);
    #2;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
